// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch flushes,
// data-memory wait holds, saturating event counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             pc_src,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err
);

  localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_nxt;
  logic            err_set;
  logic            mem_stall, branch_taken, load_use;

  assign mem_stall    = dmem_req & ~dmem_ready;
  assign branch_taken = exmem_branch & exmem_zero;
  // r0 is hardwired zero, so a load targeting it can never create a dependency
  assign load_use     = idex_memread & (idex_rt != 5'd0) &
                        ((idex_rt == id_rs) | (idex_rt == id_rt));

  always_comb begin
    pc_en       = 1'b1;
    pc_src      = 1'b0;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    state_nxt   = RUN;
    wait_nxt    = '0;
    err_set     = 1'b0;

    if (mem_stall) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      if (state == RUN) begin
        state_nxt = MEM_WAIT;
        wait_nxt  = WC_W'(1);
      end else if (wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
        // flag the timeout and restart the wait window; the hold itself continues
        err_set = 1'b1;
      end else begin
        state_nxt = MEM_WAIT;
        wait_nxt  = wait_cnt + 1'b1;
      end
    end else if (branch_taken) begin
      pc_src      = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set)
        mem_err <= 1'b1;
      if (!pc_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (pc_src && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a rule-level model.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int TMO   = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, idex_rt = '0;
  logic idex_memread = 0, exmem_branch = 0, exmem_zero = 0, dmem_req = 0, dmem_ready = 0;
  logic pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic mem_err;

  int n_tests = 0, n_fail = 0;
  int m_stall = 0, m_flush = 0, m_run = 0;
  bit m_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .idex_memread(idex_memread),
    .idex_rt(idex_rt), .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en), .pc_src(pc_src),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // expected control word {pc_en,pc_src,ifid_en,ifid_flush,idex_en,idex_flush,exmem_en,exmem_flush,memwb_en}
  function automatic logic [8:0] exp_ctl();
    bit hold = dmem_req && !dmem_ready;
    bit br   = exmem_branch && exmem_zero;
    bit lu   = idex_memread && idex_rt != 0 && (idex_rt == id_rs || idex_rt == id_rt);
    if (hold)    return 9'b0_0_0_0_0_0_0_0_0;
    else if (br) return 9'b1_1_1_1_1_1_1_1_1;
    else if (lu) return 9'b0_0_0_0_1_1_1_0_1;
    else         return 9'b1_0_1_0_1_0_1_0_1;
  endfunction

  // one clock: check outputs before the edge, then advance the model across it
  task automatic step(input string tag);
    logic [8:0] e;
    #1;
    e = exp_ctl();
    chk({tag, "_ctl"}, {23'd0, pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_flush,
                        exmem_en, exmem_flush, memwb_en}, {23'd0, e});
    chk({tag, "_stall"}, 32'(stall_cnt), 32'(m_stall));
    chk({tag, "_flush"}, 32'(flush_cnt), 32'(m_flush));
    chk({tag, "_err"}, 32'(mem_err), 32'(m_err));
    @(posedge clk);
    if (!e[8] && m_stall < SAT) m_stall++;
    if (e[7] && m_flush < SAT) m_flush++;
    if (dmem_req && !dmem_ready) begin
      m_run++;
      if (m_run == TMO) begin m_err = 1; m_run = 0; end
    end else m_run = 0;
    @(negedge clk);
  endtask

  // async pulse placed between edges, checked before any clock edge can act
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    m_stall = 0; m_flush = 0; m_run = 0; m_err = 0;
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_flush", 32'(flush_cnt), 0);
    chk("rst_err", 32'(mem_err), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; idex_rt = 0; idex_memread = 0;
    exmem_branch = 0; exmem_zero = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  initial begin
    @(negedge clk);
    chk("inrst_pc_en", 32'(pc_en), 1);
    chk("inrst_memwb_en", 32'(memwb_en), 1);
    do_reset();

    // load-use on rs: one bubble
    idex_memread = 1; idex_rt = 5; id_rs = 5; id_rt = 7;
    step("lu");
    idle(); step("lu_after");
    chk("lu_cnt", 32'(stall_cnt), 1);

    // r0 destination never stalls
    idex_memread = 1; idex_rt = 0; id_rs = 0; id_rt = 0;
    step("r0");
    idle();

    // taken branch, then not-taken
    exmem_branch = 1; exmem_zero = 1; step("br");
    exmem_zero = 0; step("br_nt");
    chk("br_cnt", 32'(flush_cnt), 1);
    idle(); do_reset();

    // memory wait: three held cycles then ready
    dmem_req = 1;
    repeat (3) step("mw");
    dmem_ready = 1; step("mw_rdy");
    chk("mw_cnt", 32'(stall_cnt), 3);
    idle(); do_reset();

    // branch waiting behind a memory hold
    dmem_req = 1; exmem_branch = 1; exmem_zero = 1;
    repeat (2) step("bm");
    dmem_ready = 1; step("bm_rdy");
    chk("bm_flush", 32'(flush_cnt), 1);
    chk("bm_stall", 32'(stall_cnt), 2);
    idle(); do_reset();

    // timeout: err rises after the 4th held edge and stays
    dmem_req = 1;
    repeat (3) step("to");
    chk("to_pre", 32'(mem_err), 0);
    repeat (6) step("to_hold");
    chk("to_sticky", 32'(mem_err), 1);
    dmem_ready = 1; step("to_rel");
    dmem_ready = 0; step("to_again");
    do_reset();
    idle(); step("post_rst");

    // counter saturation
    dmem_req = 1; repeat (20) step("sat");
    chk("sat_stall", 32'(stall_cnt), SAT);
    idle();
    repeat (20) begin exmem_branch = 1; exmem_zero = 1; step("satf"); end
    chk("sat_flush", 32'(flush_cnt), SAT);
    idle(); do_reset();

    // randomized traffic with occasional async reset
    for (int i = 0; i < 1500; i++) begin
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      idex_rt      = 5'($urandom_range(0, 3));
      idex_memread = 1'($urandom_range(0, 1));
      exmem_branch = 1'($urandom_range(0, 1));
      exmem_zero   = 1'($urandom_range(0, 1));
      dmem_req     = 1'($urandom_range(0, 1));
      dmem_ready   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
